// File: rtl/lottery_round_scheduler.sv
// ----------------------------------------------------------------------------
// lottery_round_scheduler
//
// Shares a single lottery game engine between NUM_PLAYERS consoles. Each
// console presents a full ticket of DIGITS BCD digits and raises req. A
// round-robin arbiter picks one requester, latches its ticket, and plays it
// on the engine:
//   clear pulse -> DIGITS insert pulses -> finish pulse -> wait -> result.
// The engine result (or a rejection for a non-BCD digit) is returned to the
// granted console with a one-cycle done strobe.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset; aborts a round in flight
//   req          per-console request (level)
//   ticket       flattened tickets; console p owns slice p, digit k of a
//                slice sits at bits [4k+3:4k]
//   grant        one-hot owner of the current round, 0 when idle
//   busy         a round is in progress
//   done         one-cycle result strobe to the granted console
//   done_win     win flag, valid with done
//   done_premio  prize code, valid with done
//   done_err     ticket rejected (digit > 9), valid with done
//   eng_reset    engine clear strobe
//   eng_insert   engine digit strobe
//   eng_num      engine digit value (0 when eng_insert is low)
//   eng_finish   engine finish strobe
//   eng_win      engine win result
//   eng_premio   engine prize result
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module lottery_round_scheduler #(
    parameter int NUM_PLAYERS = 4,
    parameter int DIGITS      = 5,
    parameter int RESULT_WAIT = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PLAYERS-1:0]          req,
    input  logic [NUM_PLAYERS*4*DIGITS-1:0] ticket,
    output logic [NUM_PLAYERS-1:0]          grant,
    output logic                            busy,
    output logic                            done,
    output logic                            done_win,
    output logic [1:0]                      done_premio,
    output logic                            done_err,
    output logic                            eng_reset,
    output logic                            eng_insert,
    output logic [3:0]                      eng_num,
    output logic                            eng_finish,
    input  logic                            eng_win,
    input  logic [1:0]                      eng_premio
);

    localparam int TW = 4 * DIGITS;
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WW = $clog2(RESULT_WAIT + 1);
    localparam logic [NUM_PLAYERS-1:0] GRANT_ONE = NUM_PLAYERS'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SEND,
        FIN,
        WAIT,
        REPORT
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]            sel_q, sel_d;
    logic [TW-1:0]            ticket_buf_q, ticket_buf_d;
    logic [KW-1:0]            k_q, k_d;
    logic [WW-1:0]            wait_q, wait_d;
    logic [NUM_PLAYERS-1:0]   grant_q, grant_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     done_win_q, done_win_d;
    logic [1:0]               done_premio_q, done_premio_d;
    logic                     done_err_q, done_err_d;
    logic                     eng_reset_q, eng_reset_d;
    logic                     eng_insert_q, eng_insert_d;
    logic [3:0]               eng_num_q, eng_num_d;
    logic                     eng_finish_q, eng_finish_d;

    // Per-console ticket slices and per-digit views of the latched ticket.
    logic [TW-1:0]  ticket_slice [NUM_PLAYERS];
    logic [3:0]     buf_digit    [DIGITS];
    logic [DIGITS-1:0] digit_bad;
    logic [TW-1:0]  sel_ticket;
    logic           ticket_bad;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_slice
            assign ticket_slice[gi] = ticket[gi*TW +: TW];
        end
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign buf_digit[gi] = ticket_buf_q[4*gi +: 4];
            assign digit_bad[gi] = (sel_ticket[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // Round-robin search: first asserted req at or above rr_ptr, wrapping.
    logic [PW-1:0] pick;
    logic          pick_found;
    logic [PW:0]   cand;

    always_comb begin : rr_pick
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_PLAYERS)) begin
                cand = cand - (PW+1)'(NUM_PLAYERS);
            end
            if (!pick_found && req[cand[PW-1:0]]) begin
                pick       = cand[PW-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign sel_ticket = ticket_slice[pick];
    assign ticket_bad = |digit_bad;

    logic [KW-1:0] k_inc;
    assign k_inc = k_q + KW'(1);

    always_comb begin : next_state
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        sel_d         = sel_q;
        ticket_buf_d  = ticket_buf_q;
        k_d           = k_q;
        wait_d        = wait_q;
        grant_d       = grant_q;
        done_d        = 1'b0;
        done_win_d    = 1'b0;
        done_premio_d = 2'b00;
        done_err_d    = 1'b0;
        eng_reset_d   = 1'b0;
        eng_insert_d  = 1'b0;
        eng_num_d     = 4'd0;
        eng_finish_d  = 1'b0;

        // Outputs are computed one cycle ahead so that each strobe lines up
        // with the state it belongs to once registered.
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d        = pick;
                    ticket_buf_d = sel_ticket;
                    grant_d      = GRANT_ONE << pick;
                    if (ticket_bad) begin
                        // Rejected tickets never touch the engine.
                        state_d    = REPORT;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else begin
                        state_d     = CLR;
                        eng_reset_d = 1'b1;
                    end
                end
            end
            CLR: begin
                state_d      = SEND;
                k_d          = '0;
                eng_insert_d = 1'b1;
                eng_num_d    = buf_digit[0];
            end
            SEND: begin
                // k_q is the digit currently on eng_num.
                if (k_q == KW'(DIGITS - 1)) begin
                    state_d      = FIN;
                    eng_finish_d = 1'b1;
                end else begin
                    k_d          = k_inc;
                    eng_insert_d = 1'b1;
                    eng_num_d    = buf_digit[k_inc];
                end
            end
            FIN: begin
                state_d = WAIT;
                wait_d  = WW'(RESULT_WAIT);
            end
            WAIT: begin
                wait_d = wait_q - WW'(1);
                if (wait_q == WW'(1)) begin
                    state_d       = REPORT;
                    done_d        = 1'b1;
                    done_win_d    = eng_win;
                    done_premio_d = eng_premio;
                end
            end
            REPORT: begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = (sel_q == PW'(NUM_PLAYERS - 1)) ? '0 : sel_q + PW'(1);
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            sel_q         <= '0;
            ticket_buf_q  <= '0;
            k_q           <= '0;
            wait_q        <= '0;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            done_win_q    <= 1'b0;
            done_premio_q <= 2'b00;
            done_err_q    <= 1'b0;
            eng_reset_q   <= 1'b0;
            eng_insert_q  <= 1'b0;
            eng_num_q     <= 4'd0;
            eng_finish_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            sel_q         <= sel_d;
            ticket_buf_q  <= ticket_buf_d;
            k_q           <= k_d;
            wait_q        <= wait_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            done_win_q    <= done_win_d;
            done_premio_q <= done_premio_d;
            done_err_q    <= done_err_d;
            eng_reset_q   <= eng_reset_d;
            eng_insert_q  <= eng_insert_d;
            eng_num_q     <= eng_num_d;
            eng_finish_q  <= eng_finish_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign done_win    = done_win_q;
    assign done_premio = done_premio_q;
    assign done_err    = done_err_q;
    assign eng_reset   = eng_reset_q;
    assign eng_insert  = eng_insert_q;
    assign eng_num     = eng_num_q;
    assign eng_finish  = eng_finish_q;

endmodule

// File: doc/lottery_round_scheduler.md
Name: lottery_round_scheduler

Overview:
- Shares one lottery game engine among NUM_PLAYERS player consoles.
- Each console posts a full ticket of DIGITS BCD digits. The scheduler picks one console by round-robin and latches its ticket.
- It then clears the engine, replays the digits as single-cycle insert pulses, issues finish, samples win/prize, and returns the result to the granted console.
- Sits between the console front-ends and the game engine; it is the engine's only driver.

Parameters:
NUM_PLAYERS, 4, number of requesting consoles (2..8)
DIGITS, 5, digits per ticket
RESULT_WAIT, 2, cycles from the finish pulse to the engine result sample (min 1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_PLAYERS  per-console ticket request, level
ticket  in  NUM_PLAYERS*4*DIGITS  flattened tickets; console p uses slice p; digit k at bits [4k+3:4k] of that slice
grant  out  NUM_PLAYERS  one-hot owner of the current round, else 0
busy  out  1  round in progress (state != IDLE)
done  out  1  one-cycle result strobe to the granted console
done_win  out  1  win flag, valid with done
done_premio  out  2  prize code, valid with done
done_err  out  1  ticket rejected (digit > 9), valid with done
eng_reset  out  1  engine clear pulse
eng_insert  out  1  engine digit strobe
eng_num  out  4  engine digit value
eng_finish  out  1  engine finish strobe
eng_win  in  1  engine win result
eng_premio  in  2  engine prize result

Behaviour:
- Reset: state IDLE; rr_ptr=0; grant=0.
- Reset forces every other output to 0: busy, done, done_win, done_premio, done_err, eng_reset, eng_insert, eng_num, eng_finish.
- Reset mid-round aborts the round immediately. No done is issued and no engine strobes follow.
- All outputs are registered.
- States: IDLE, CLR, SEND, FIN, WAIT, REPORT.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: pick the first set req at or after rr_ptr, searching upward with wrap; call it p.
  - Latch ticket slice p into an internal buffer and set grant=onehot(p).
  - If any digit > 9: go to REPORT with err set. The engine is untouched.
  - Otherwise go to CLR.
- Consoles may change ticket or drop req after the grant cycle; the latched copy is used.
- CLR: eng_reset=1 for exactly one cycle, then go to SEND with digit counter k=0.
- SEND, one cycle per digit: eng_insert=1 and eng_num=buf[k].
  - k increments each cycle.
  - After k==DIGITS-1, go to FIN.
  - Exactly DIGITS insert pulses, back to back, digit 0 first.
- FIN: eng_finish=1 for one cycle. Load wait counter=RESULT_WAIT, go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, register eng_win/eng_premio, then go to REPORT.
- REPORT: done=1 for one cycle, together with done_win, done_premio and done_err.
  - On the error path done_win=0 and done_premio=0.
  - Set rr_ptr=(p+1) mod NUM_PLAYERS.
  - Next state IDLE; grant drops to 0 in that next cycle.
- eng_num holds 0 whenever eng_insert=0.
- eng_reset, eng_insert and eng_finish are never active in the same cycle.
- Latency, valid ticket, req seen in IDLE at cycle 0:
  - grant and eng_reset in cycle 1;
  - inserts in cycles 2..DIGITS+1;
  - finish in cycle DIGITS+2;
  - done in cycle DIGITS+3+RESULT_WAIT (cycle 10 with defaults).
- Latency, invalid ticket: done with err at cycle 1.
- Requests arriving during a round wait; req is sampled only in IDLE.
- A console still holding req at done may be re-granted only after every other requester has been served (round-robin fairness).
- Simultaneous requests: the lowest index at or after rr_ptr wins; wrap from NUM_PLAYERS-1 to 0.

Test Plan:
- Single console, default params: req[0]=1, ticket0 digits 5,0,9,6,7; engine model returns win=1, premio=01. Expect eng_reset at cycle 1, inserts 5,0,9,6,7 in cycles 2-6, finish at cycle 7, done at cycle 10 with done_win=1, done_premio=01, grant=0001 in cycles 1-10.
- Contention: req=1111 held from reset release. Expect grant order 0001,0010,0100,1000,0001, with one IDLE cycle between rounds.
- Pointer wrap: after serving console 2, assert req=0011. Expect console 0 granted first, then console 1.
- Invalid ticket: console 1 digit 3 = 4'hC. Expect done with done_err=1, done_win=0, done_premio=00 at cycle 1, and no eng_reset, eng_insert or eng_finish pulses.
- Reset mid-SEND after the third insert. Expect all outputs 0 in the next cycle, no finish and no done; a fresh req restarts cleanly from CLR.
- Ticket changed after grant: alter the ticket0 bus in cycle 2. Expect the inserted digits to match the ticket latched in the grant cycle.
